// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// piso_serializer_if
// Word-in / bit-out handshake bundle for piso_serializer.
//   in_data   : parallel word to serialize
//   in_valid  : in_data is valid
//   in_ready  : serializer can take a word this cycle
//   stall     : freezes shifting while high
//   data_out  : serial bit, MSB first
//   shift_en  : data_out is valid this cycle
//   word_done : pulse on the last bit of a word
//   busy      : serializer is shifting
// slave  = serializer side, master = word producer / bit consumer side.
// ---------------------------------------------------------------------------
interface piso_serializer_if #(
    parameter int unsigned SIZE = 8
);
    logic [SIZE-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic            stall;
    logic            data_out;
    logic            shift_en;
    logic            word_done;
    logic            busy;

    modport slave (
        input  in_data,
        input  in_valid,
        input  stall,
        output in_ready,
        output data_out,
        output shift_en,
        output word_done,
        output busy
    );

    modport master (
        output in_data,
        output in_valid,
        output stall,
        input  in_ready,
        input  data_out,
        input  shift_en,
        input  word_done,
        input  busy
    );
endinterface

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// piso_serializer
// Parallel-in / serial-out shifter, MSB first, with a one-word pending
// buffer so consecutive words stream out without idle cycles.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-low reset
//   bus   : piso_serializer_if.slave (word handshake, stall, serial outputs)
// ---------------------------------------------------------------------------
module piso_serializer #(
    parameter int unsigned SIZE = 8
) (
    input logic               clk,
    input logic               reset,
    piso_serializer_if.slave  bus
);

    localparam int unsigned    CntW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(SIZE - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e          state_q, state_d;
    logic [SIZE-1:0] sreg_q, sreg_d;
    logic [SIZE-1:0] pend_q, pend_d;
    logic            pend_full_q, pend_full_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic shift_en;
    logic last_bit;
    logic in_ready;
    logic accept;

    always_comb begin
        shift_en = (state_q == StShift) && !bus.stall;
        last_bit = shift_en && (cnt_q == '0);
        // Ready drops combinationally with reset so nothing is accepted during it.
        in_ready = reset && !pend_full_q;
        accept   = bus.in_valid && in_ready;
    end

    assign bus.shift_en  = shift_en;
    assign bus.word_done = last_bit;
    assign bus.data_out  = sreg_q[SIZE-1];
    assign bus.busy      = (state_q == StShift);
    assign bus.in_ready  = in_ready;

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        cnt_d       = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    sreg_d  = bus.in_data;
                    cnt_d   = CntLast;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit) begin
                    if (pend_full_q) begin
                        sreg_d      = pend_q;
                        pend_full_d = 1'b0;
                        cnt_d       = CntLast;
                    end else if (accept) begin
                        // Bypass pending so the next word follows with no bubble.
                        sreg_d = bus.in_data;
                        cnt_d  = CntLast;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (shift_en) begin
                    sreg_d = {sreg_q[SIZE-2:0], 1'b0};
                    cnt_d  = cnt_q - CntW'(1);
                end
                // Covers normal and stalled cycles; on a last-bit edge accept can
                // only occur with pending empty, and that word was bypassed above.
                if (accept && !last_bit) begin
                    pend_d      = bus.in_data;
                    pend_full_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            sreg_q      <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
